status_register_unit: RTL and testbench

//  - Producer side of the NZCV flags read by the condition-check logic in ID.
//  - Computes flags from the EXE-stage ALU result and holds the architectural status register.
//  - Also holds a saved copy for exception entry/return, and accepts MSR-style direct writes.
//  - Flag word layout (fixed, consumer unpacks identically): [3]=Z [2]=C [1]=N [0]=V.

---
 rtl/status_register_unit_pkg.sv | 26 ++
 rtl/status_register_unit_flag_gen.sv | 23 ++
 rtl/status_register_unit.sv | 134 +++++++++++++
 tb/tb_status_register_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/status_register_unit_pkg.sv
// Shared definitions for the status register unit: flag word layout,
// FSM state encoding and the masked flag merge helper.
package status_register_unit_pkg;

    // Flag word layout, shared with the condition-check consumer.
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 0;

    typedef logic [FLAG_W-1:0] flags_t;

    // RUN: no saved copy live. HELD: saved copy taken on exception entry.
    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StHeld = 1'b1
    } sru_state_e;

    // Take masked bits from the freshly generated flags, keep the rest.
    function automatic flags_t merge_flags(input flags_t gen, input flags_t old,
                                           input flags_t mask);
        return (gen & mask) | (old & ~mask);
    endfunction

endpackage

// File: rtl/status_register_unit_flag_gen.sv
// Combinational NZCV generation from the EXE-stage ALU result.
// Output word is ordered ZCNV (Z in the MSB).
module flag_gen
    import status_register_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_c,
    input  logic                  alu_v,
    output logic [FLAG_W-1:0]     flags
);

    // Pack the four generated flags into the fixed word layout.
    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (alu_result == '0);
        flags[FLAG_C] = alu_c;
        flags[FLAG_N] = alu_result[DATA_WIDTH-1];
        flags[FLAG_V] = alu_v;
    end

endmodule

// File: rtl/status_register_unit.sv
// Architectural NZCV status register with exception save/restore, MSR-style
// direct writes and a saturating count of committed flag updates.
// Optional feature macro: FLAG_FORWARD_EN -- when defined, cond_flags bypasses
// the register with the same-cycle update value; otherwise cond_flags is the
// registered status.
module status_register_unit
    import status_register_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exe_valid,
    input  logic                  s_bit,
    input  logic [FLAG_W-1:0]     flag_mask,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_c,
    input  logic                  alu_v,
    input  logic                  stall,
    input  logic                  msr_we,
    input  logic [FLAG_W-1:0]     msr_data,
    input  logic                  exc_enter,
    input  logic                  exc_return,
    output logic [FLAG_W-1:0]     status_register,
    output logic [FLAG_W-1:0]     cond_flags,
    output logic                  saved_valid,
    output logic [CNT_W-1:0]      update_count
);

    sru_state_e       state_q, state_d;
    flags_t           flags_q, flags_d;
    flags_t           saved_q, saved_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    flags_t gen_flags;
    flags_t upd_flags;
    logic   enter_req;
    logic   msr_go;
    logic   upd_go;
    logic   do_save;
    logic   do_restore;
    logic   cnt_inc;

    flag_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_flag_gen (
        .alu_result (alu_result),
        .alu_c      (alu_c),
        .alu_v      (alu_v),
        .flags      (gen_flags)
    );

    // Request arbitration: exc_return > exc_enter > msr_we > upd. Any asserted
    // higher-priority request squashes the lower ones, even if it has no
    // effect in the current state. Stall blocks only msr_we and upd.
    always_comb begin
        enter_req  = exc_enter & ~exc_return;
        msr_go     = rst & msr_we & ~stall & ~exc_return & ~exc_enter;
        upd_go     = rst & exe_valid & s_bit & ~stall & ~exc_return & ~exc_enter & ~msr_we;
        do_restore = rst & exc_return & (state_q == StHeld);
        do_save    = rst & enter_req & (state_q == StRun);
        upd_flags  = merge_flags(gen_flags, flags_q, flag_mask);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: save moves to HELD, restore returns to RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (do_save)    state_d = StHeld;
            StHeld:  if (do_restore) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // FSM outputs and datapath next values.
    always_comb begin
        flags_d = flags_q;
        saved_d = saved_q;
        cnt_inc = 1'b0;
        if (do_restore) begin
            flags_d = saved_q;
        end else if (msr_go) begin
            flags_d = msr_data;
            cnt_inc = 1'b1;
        end else if (upd_go) begin
            flags_d = upd_flags;
            cnt_inc = 1'b1;
        end
        // Saved copy captures the pre-update value; it is the only writer.
        if (do_save) begin
            saved_d = flags_q;
        end
        if (cnt_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Flag, saved-copy and counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            flags_q <= '0;
            saved_q <= '0;
            cnt_q   <= '0;
        end else begin
            flags_q <= flags_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

    assign status_register = flags_q;
    assign saved_valid     = (state_q == StHeld);
    assign update_count    = cnt_q;

`ifdef FLAG_FORWARD_EN
    // Same-cycle EXE->ID bypass of a committing flag-setting instruction.
    assign cond_flags = upd_go ? upd_flags : flags_q;
`else
    assign cond_flags = flags_q;
`endif

endmodule

// File: tb/tb_status_register_unit.sv
// Scoreboard bench for status_register_unit: stimulus pushes expected values
// from a behavioural model; monitors pop and compare.
module tb_status_register_unit;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          exe_valid = 1'b0, s_bit = 1'b0, stall = 1'b0;
    logic          alu_c = 1'b0, alu_v = 1'b0;
    logic          msr_we = 1'b0, exc_enter = 1'b0, exc_return = 1'b0;
    logic [3:0]    flag_mask = '0, msr_data = '0;
    logic [DW-1:0] alu_result = '0;
    logic [3:0]    status_register, cond_flags;
    logic          saved_valid;
    logic [CW-1:0] update_count;

    status_register_unit #(
        .DATA_WIDTH (DW),
        .CNT_W      (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .exe_valid       (exe_valid),
        .s_bit           (s_bit),
        .flag_mask       (flag_mask),
        .alu_result      (alu_result),
        .alu_c           (alu_c),
        .alu_v           (alu_v),
        .stall           (stall),
        .msr_we          (msr_we),
        .msr_data        (msr_data),
        .exc_enter       (exc_enter),
        .exc_return      (exc_return),
        .status_register (status_register),
        .cond_flags      (cond_flags),
        .saved_valid     (saved_valid),
        .update_count    (update_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    flags;
        logic          sv;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t       st_q[$];
    logic [3:0] cond_q[$];
    int         checks = 0;
    int         failures = 0;

    // Reference model state
    logic [3:0] m_flags = '0, m_saved = '0;
    logic       m_held = 1'b0, m_known = 1'b0;
    int         m_cnt = 0;

    function automatic logic [3:0] gen_zcnv(input logic [DW-1:0] res, input logic c,
                                            input logic v);
        return {res == 0, c, res[DW-1], v};
    endfunction

    function automatic logic [3:0] masked(input logic [3:0] g, input logic [3:0] old,
                                          input logic [3:0] m);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = m[i] ? g[i] : old[i];
        return r;
    endfunction

    task automatic cycle(input logic r, input logic ev, input logic sb, input logic [3:0] mk,
                         input logic [DW-1:0] res, input logic c, input logic v,
                         input logic st, input logic mw, input logic [3:0] md,
                         input logic ee, input logic er);
        logic       upd_commits;
        logic [3:0] upd_val;
        exp_t       e;
        @(negedge clk);
        rst = r; exe_valid = ev; s_bit = sb; flag_mask = mk; alu_result = res;
        alu_c = c; alu_v = v; stall = st; msr_we = mw; msr_data = md;
        exc_enter = ee; exc_return = er;
        #1;
        upd_commits = r && !er && !ee && !mw && ev && sb && !st;
        upd_val     = masked(gen_zcnv(res, c, v), m_flags, mk);
        if (m_known) begin
`ifdef FLAG_FORWARD_EN
            cond_q.push_back(upd_commits ? upd_val : m_flags);
`else
            cond_q.push_back(m_flags);
`endif
        end
        // Advance model by one clock edge, highest-priority request first.
        if (!r) begin
            m_flags = '0; m_saved = '0; m_held = 1'b0; m_cnt = 0; m_known = 1'b1;
        end else if (er) begin
            if (m_held) begin
                m_flags = m_saved;
                m_held  = 1'b0;
            end
        end else if (ee) begin
            if (!m_held) begin
                m_saved = m_flags;
                m_held  = 1'b1;
            end
        end else if (mw && !st) begin
            m_flags = md;
            m_cnt   = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
        end else if (upd_commits) begin
            m_flags = upd_val;
            m_cnt   = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
        end
        if (m_known) begin
            e.flags = m_flags; e.sv = m_held; e.cnt = CW'(m_cnt);
            st_q.push_back(e);
        end
    endtask

    task automatic idle();
        cycle(1, 0, 0, 4'h0, 32'h1, 0, 0, 0, 0, 4'h0, 0, 0);
    endtask

    task automatic msr(input logic [3:0] d);
        cycle(1, 0, 0, 4'h0, 32'h1, 0, 0, 0, 1, d, 0, 0);
    endtask

    // Registered-state monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                checks++;
                if (status_register !== e.flags || saved_valid !== e.sv ||
                    update_count !== e.cnt) begin
                    failures++;
                    $display("FAIL state t=%0t got flags=%b sv=%b cnt=%0d want flags=%b sv=%b cnt=%0d",
                             $time, status_register, saved_valid, update_count,
                             e.flags, e.sv, e.cnt);
                end
            end
        end
    end

    // Condition-flag monitor, sampled mid-cycle after inputs settle
    initial begin
        logic [3:0] c;
        forever begin
            @(negedge clk);
            #2;
            if (cond_q.size() > 0) begin
                c = cond_q.pop_front();
                checks++;
                if (cond_flags !== c) begin
                    failures++;
                    $display("FAIL cond_flags t=%0t got=%b want=%b", $time, cond_flags, c);
                end
            end
        end
    end

    initial begin
        // Reset for two cycles
        cycle(0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 4'h0, 0, 0);
        cycle(0, 1, 1, 4'hF, 32'h0, 1, 1, 0, 1, 4'hF, 1, 0);
        // SUBS result zero, C=1: expect 1100, count 1
        cycle(1, 1, 1, 4'hF, 32'h0, 1, 0, 0, 0, 4'h0, 0, 0);
        // Logical op on prior 0101 with mask 1010: expect 0111
        msr(4'b0101);
        cycle(1, 1, 1, 4'b1010, 32'h8000_0000, 0, 0, 0, 0, 4'h0, 0, 0);
        // Save / modify / restore
        msr(4'b1000);
        cycle(1, 0, 0, 4'h0, 32'h1, 0, 0, 0, 0, 4'h0, 1, 0);
        msr(4'b0010);
        cycle(1, 0, 0, 4'h0, 32'h1, 0, 0, 0, 0, 4'h0, 0, 1);
        // Stall blocks both upd and msr
        cycle(1, 1, 1, 4'hF, 32'h0, 1, 1, 1, 1, 4'hA, 0, 0);
        // Exception entry with msr in same cycle: msr dropped
        cycle(1, 0, 0, 4'h0, 32'h1, 0, 0, 0, 1, 4'hF, 1, 0);
        // Nested entry ignored, upd in HELD updates flags only
        cycle(1, 1, 1, 4'hF, 32'h5, 1, 1, 0, 0, 4'h0, 1, 0);
        cycle(1, 1, 1, 4'hF, 32'hFFFF_FFFF, 0, 1, 0, 0, 4'h0, 0, 0);
        // Enter+return together in HELD: return wins
        cycle(1, 1, 1, 4'hF, 32'h0, 0, 0, 0, 0, 4'h0, 1, 1);
        // Return in RUN and the pair in RUN: no effect
        cycle(1, 1, 1, 4'hF, 32'h0, 0, 0, 0, 0, 4'h0, 0, 1);
        cycle(1, 0, 0, 4'h0, 32'h1, 0, 0, 0, 1, 4'h3, 1, 1);
        // Update to 0100, then an idle cycle for the unforwarded view
        cycle(1, 1, 1, 4'hF, 32'h0000_0010, 1, 0, 0, 0, 4'h0, 0, 0);
        idle();
        // Invalid / s_bit-less instructions do not update
        cycle(1, 0, 1, 4'hF, 32'h0, 1, 1, 0, 0, 4'h0, 0, 0);
        cycle(1, 1, 0, 4'hF, 32'h0, 1, 1, 0, 0, 4'h0, 0, 0);
        // Drive the counter into saturation
        for (int i = 0; i < 20; i++) msr(4'(i));
        cycle(1, 1, 1, 4'hF, 32'h0, 1, 1, 0, 0, 4'h0, 0, 0);
        // Reset while HELD drops the saved copy
        cycle(1, 0, 0, 4'h0, 32'h1, 0, 0, 0, 0, 4'h0, 1, 0);
        cycle(0, 0, 0, 4'h0, 32'h1, 0, 0, 0, 0, 4'h0, 0, 0);
        cycle(1, 0, 0, 4'h0, 32'h1, 0, 0, 0, 0, 4'h0, 0, 1);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [DW-1:0] res;
            res = $urandom();
            if ($urandom_range(3) == 0) res = '0;
            cycle($urandom_range(99) != 0, $urandom_range(3) != 0, $urandom_range(3) != 0,
                  4'($urandom()), res, 1'($urandom()), 1'($urandom()),
                  $urandom_range(3) == 0, $urandom_range(5) == 0, 4'($urandom()),
                  $urandom_range(9) == 0, $urandom_range(9) == 0);
        end
        idle();
        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && (st_q.size() > 0 || cond_q.size() > 0); i++)
            @(posedge clk);
        #5;
        checks++;
        if (st_q.size() != 0 || cond_q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d/%0d want 0/0", st_q.size(), cond_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
